// File: rtl/serial_tx_uart_pkg.sv
// Shared types and frame constants for the serial TX UART.
package serial_tx_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/serial_tx_uart_sync_fifo.sv
// Circular-buffer FIFO with registered occupancy count; head is visible on pop_data.
module serial_tx_uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_tx_uart.sv
// Byte-write FIFO feeding an 8N1 UART transmitter with back-to-back frames.
module serial_tx_uart
    import serial_tx_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    input  logic [31:0]               wr_data,
    output logic                      wr_ready,
    output logic                      tx,
    output logic                      tx_busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [BW-1:0]        baud;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 empty;
    logic                 full;
    logic                 push_c;
    logic                 pop_c;
    logic                 tx_c;
    logic                 baud_last;
    logic                 data_last;
    logic                 stop_last;
    logic [CW-1:0]        count_next;
    logic                 unused_bits;

    assign unused_bits = ^{wr_data[31:8], full};
    assign push_c      = wr_valid && wr_ready;
    assign baud_last   = (baud == BW'(CLKS_PER_BIT - 1));
    assign data_last   = (bit_idx == IW'(DATA_BITS - 1));
    assign stop_last   = (bit_idx == IW'(STOP_BITS - 1));
    assign count_next  = fifo_count + CW'(push_c) - CW'(pop_c);

    serial_tx_uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (wr_data[DATA_BITS-1:0]),
        .pop       (pop_c),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (!empty) state_next = ST_START;
            ST_START: if (baud_last) state_next = ST_DATA;
            ST_DATA:  if (baud_last && data_last) state_next = ST_STOP;
            ST_STOP:  if (baud_last && stop_last) state_next = empty ? ST_IDLE : ST_START;
        endcase
    end

    // Pop from IDLE, or on the final stop cycle so frames abut without a gap.
    always_comb begin
        pop_c = 1'b0;
        tx_c  = 1'b1;
        unique case (state)
            ST_IDLE:  pop_c = !empty;
            ST_START: tx_c  = 1'b0;
            ST_DATA:  tx_c  = shift[0];
            ST_STOP:  pop_c = !empty && baud_last && stop_last;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            wr_ready <= 1'b1;
            overflow <= 1'b0;
        end else begin
            tx       <= tx_c;
            tx_busy  <= (state_next != ST_IDLE) || (count_next != '0);
            wr_ready <= (count_next < CW'(DEPTH));
            if (wr_valid && !wr_ready) overflow <= 1'b1;

            if (state == ST_IDLE || baud_last) baud <= '0;
            else                               baud <= baud + BW'(1);

            if (baud_last) begin
                if (state_next != state) bit_idx <= '0;
                else                     bit_idx <= bit_idx + IW'(1);
            end

            if (pop_c)                            shift <= head;
            else if (state == ST_DATA && baud_last) shift <= {1'b0, shift[DATA_BITS-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_tx_uart.sv
// Self-checking bench: frame-level reference model plus table vectors and corner sequences.
module tb_serial_tx_uart;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;
    localparam int          FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          tx;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;

    serial_tx_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue, time of last pop and the byte in flight.
    logic [7:0] mq[$];
    int         t        = 0;
    int         last_pop = -1000;
    int         free_at  = 0;
    logic [7:0] cur      = 8'h00;
    logic       m_ovf    = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic [9:0]  line;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic slot_bit(input logic [7:0] b, input int s);
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        last_pop = -1000;
        free_at  = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d);
        int  sz;
        bit  do_pop;
        t++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz     = mq.size();
        do_pop = (sz > 0) && (t >= free_at);
        if (v && sz >= DEPTH) m_ovf = 1'b1;
        if (do_pop) begin
            cur      = mq.pop_front();
            last_pop = t;
            free_at  = t + FRAME;
        end
        if (v && sz < DEPTH) mq.push_back(d[7:0]);
    endtask

    function automatic logic [31:0] model_outputs();
        int   k;
        logic e_tx;
        logic e_busy;
        k      = t - last_pop - 1;
        e_tx   = (k >= 0 && k < FRAME) ? slot_bit(cur, k / CPB) : 1'b1;
        e_busy = (mq.size() > 0) || ((t - last_pop) < FRAME);
        return {25'd0, e_tx, e_busy, logic'(mq.size() < DEPTH), m_ovf, CW'(mq.size())};
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d);
        wr_valid = v;
        wr_data  = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        check($sformatf("t%0d_outputs", t),
              {25'd0, tx, tx_busy, wr_ready, overflow, fifo_count}, model_outputs());
        wr_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h000000A5, 10'b1101001010};
        vecs[1] = '{32'hFFFFFF3C, 10'b1001111000};
        vecs[2] = '{32'h00000000, 10'b1000000000};
        vecs[3] = '{32'h000000FF, 10'b1111111110};
        vecs[4] = '{32'h12345680, 10'b1100000000};
        vecs[5] = '{32'hABCDEF01, 10'b1000000010};

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        repeat (3) cycle(1'b0, 32'h0);
        check("reset_state", {27'd0, tx, wr_ready, tx_busy, overflow, fifo_count == 0},
              32'b11001);
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 32'h0);

        // Single frames from idle: line sampled mid-slot against the table.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vecs[i].word);
            cycle(1'b0, 32'h0);
            for (int s = 0; s < 10; s++) begin
                cycle(1'b0, 32'h0);
                cycle(1'b0, 32'h0);
                check($sformatf("vec%0d_slot%0d_tx", i, s), 32'(tx), 32'(vecs[i].line[s]));
                check($sformatf("vec%0d_slot%0d_busy", i, s), 32'(tx_busy), 32'd1);
                cycle(1'b0, 32'h0);
                cycle(1'b0, 32'h0);
            end
            check($sformatf("vec%0d_idle_busy", i), 32'(tx_busy), 32'd0);
            check($sformatf("vec%0d_idle_tx", i), 32'(tx), 32'd1);
        end

        // Two back-to-back frames: stop bit directly followed by next start bit.
        cycle(1'b1, 32'h12);
        cycle(1'b1, 32'h34);
        repeat (40) cycle(1'b0, 32'h0);
        check("b2b_stop_high", 32'(tx), 32'd1);
        cycle(1'b0, 32'h0);
        check("b2b_next_start_low", 32'(tx), 32'd0);
        repeat (38) cycle(1'b0, 32'h0);
        check("b2b_busy_before_end", 32'(tx_busy), 32'd1);
        cycle(1'b0, 32'h0);
        check("b2b_busy_after_80", 32'(tx_busy), 32'd0);
        repeat (3) cycle(1'b0, 32'h0);

        // Six writes into a 4-deep FIFO: the sixth is dropped and overflow sticks.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 32'(i));
            if (i == 5) check("ovf_ready_low", 32'(wr_ready), 32'd0);
        end
        check("ovf_flag_set", 32'(overflow), 32'd1);
        check("ovf_count_full", 32'(fifo_count), 32'd4);
        repeat (5 * FRAME + 5) cycle(1'b0, 32'h0);
        check("ovf_flag_sticky", 32'(overflow), 32'd1);
        check("ovf_drained", 32'(fifo_count), 32'd0);

        // Reset mid-frame with bytes queued: line high at once, FIFO emptied.
        cycle(1'b1, 32'h5A);
        cycle(1'b1, 32'h11);
        cycle(1'b1, 32'h22);
        repeat (11) cycle(1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        repeat (2) cycle(1'b0, 32'h0);
        rst_n = 1'b1;
        cycle(1'b1, 32'h0000003C);
        repeat (FRAME + 5) cycle(1'b0, 32'h0);
        check("rst_resume_idle", 32'(tx_busy), 32'd0);

        // Randomized traffic with occasional bursts, then drain.
        for (int i = 0; i < 1500; i++) begin
            logic v;
            v = ($urandom_range(0, 15) == 0) || (i % 200 < 6 && i > 600);
            cycle(v, $urandom);
        end
        repeat (DEPTH * FRAME + FRAME + 5) cycle(1'b0, 32'h0);
        check("final_idle", {30'd0, tx_busy, tx}, 32'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
